reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_read_port.sv | 33 +++
 rtl/reg_file.sv | 72 +++++++
 tb/tb_reg_file.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and helpers for the register file and its read ports.
package reg_file_pkg;

  // Mirrors the shared bus widths: 32-bit data, 5-bit register address.
  localparam int DATA_BUS     = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int NUM_REGS     = 1 << REG_ADDR_BUS;
  localparam int COUNT_W      = 32;

  // A write only lands when it is requested and does not target r0.
  function automatic logic is_effective_write(input logic en,
                                              input logic [REG_ADDR_BUS-1:0] addr);
    return en && (addr != '0);
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: enable gating, r0 forced to
// zero, and same-cycle bypass of an in-flight effective write.
module reg_read_port
  import reg_file_pkg::*;
(
  input  logic                    rst,
  input  logic                    en,
  input  logic [REG_ADDR_BUS-1:0] addr,
  input  logic [DATA_BUS-1:0]     stored,
  input  logic                    write_hit,
  input  logic [REG_ADDR_BUS-1:0] write_addr,
  input  logic [DATA_BUS-1:0]     write_data,
  output logic [DATA_BUS-1:0]     data
);

  logic bypass;

  // write_hit already excludes r0, so the bypass can never expose r0 data.
  assign bypass = write_hit && (addr == write_addr);

  // Priority: reset and disabled port read zero, then r0, then bypass, then storage.
  always_comb begin
    data = '0;
    if (rst && en && (addr != '0)) begin
      if (bypass) begin
        data = write_data;
      end else begin
        data = stored;
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file with two bypassed read ports, an unbypassed
// debug read port and a count of effective writes.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_en,
  input  logic [REG_ADDR_BUS-1:0] write_addr,
  input  logic [DATA_BUS-1:0]     write_data,
  input  logic                    read_en_1,
  input  logic [REG_ADDR_BUS-1:0] read_addr_1,
  output logic [DATA_BUS-1:0]     read_data_1,
  input  logic                    read_en_2,
  input  logic [REG_ADDR_BUS-1:0] read_addr_2,
  output logic [DATA_BUS-1:0]     read_data_2,
  input  logic [REG_ADDR_BUS-1:0] debug_addr,
  output logic [DATA_BUS-1:0]     debug_data,
  output logic [COUNT_W-1:0]      write_count
);

  logic [DATA_BUS-1:0] regs [NUM_REGS];
  logic                write_hit;

  assign write_hit = is_effective_write(write_en, write_addr);

  // Storage: cleared asynchronously; r0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[write_addr] <= write_data;
    end
  end

  // Effective-write counter, wraps naturally at the top of its range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_count <= '0;
    end else if (write_hit) begin
      write_count <= write_count + 1'b1;
    end
  end

  // Debug view shows committed storage only, never the in-flight write.
  assign debug_data = (rst && (debug_addr != '0)) ? regs[debug_addr] : '0;

  reg_read_port read_port_1 (
    .rst        (rst),
    .en         (read_en_1),
    .addr       (read_addr_1),
    .stored     (regs[read_addr_1]),
    .write_hit  (write_hit),
    .write_addr (write_addr),
    .write_data (write_data),
    .data       (read_data_1)
  );

  reg_read_port read_port_2 (
    .rst        (rst),
    .en         (read_en_2),
    .addr       (read_addr_2),
    .stored     (regs[read_addr_2]),
    .write_hit  (write_hit),
    .write_addr (write_addr),
    .write_data (write_data),
    .data       (read_data_2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, writes, r0 discard, bypass, enable
// gating, debug port and asynchronous mid-sequence reset.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        read_en_1;
  logic [4:0]  read_addr_1;
  logic [31:0] read_data_1;
  logic        read_en_2;
  logic [4:0]  read_addr_2;
  logic [31:0] read_data_2;
  logic [4:0]  debug_addr;
  logic [31:0] debug_data;
  logic [31:0] write_count;

  int checks = 0;
  int passes = 0;

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_en_1   (read_en_1),
    .read_addr_1 (read_addr_1),
    .read_data_1 (read_data_1),
    .read_en_2   (read_en_2),
    .read_addr_2 (read_addr_2),
    .read_data_2 (read_data_2),
    .debug_addr  (debug_addr),
    .debug_data  (debug_data),
    .write_count (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    write_en   = 1'b1;
    write_addr = a;
    write_data = d;
    tick();
    write_en   = 1'b0;
    write_data = 32'h0;
    write_addr = 5'd0;
  endtask

  initial begin
    rst = 1'b0;
    write_en = 1'b1; write_addr = 5'd4; write_data = 32'hA5A5A5A5;
    read_en_1 = 1'b1; read_addr_1 = 5'd4;
    read_en_2 = 1'b1; read_addr_2 = 5'd4;
    debug_addr = 5'd4;
    #2;
    // Outputs forced to zero under reset, even with a bypass candidate present.
    check("rst_rd1", read_data_1, 32'h0);
    check("rst_rd2", read_data_2, 32'h0);
    check("rst_dbg", debug_data, 32'h0);
    check("rst_wc", write_count, 32'h0);
    tick();
    tick();
    // Write present during reset edges must be discarded.
    write_en = 1'b0; write_addr = 5'd0; write_data = 32'h0;
    #2 rst = 1'b1;
    #1;
    check("rst_discard_dbg", debug_data, 32'h0);

    // All registers read zero on both ports after reset.
    for (int i = 0; i < 32; i++) begin
      read_addr_1 = 5'(i);
      read_addr_2 = 5'(i);
      debug_addr  = 5'(i);
      #1;
      check($sformatf("init_rd1_r%0d", i), read_data_1, 32'h0);
      check($sformatf("init_rd2_r%0d", i), read_data_2, 32'h0);
    end
    check("init_wc", write_count, 32'h0);

    // Basic write then read.
    do_write(5'd5, 32'h12345678);
    read_addr_1 = 5'd5;
    #1;
    check("r5_rd1", read_data_1, 32'h12345678);
    check("r5_wc", write_count, 32'd1);

    // Stored value is returned when write_en is low even if addresses match.
    write_addr = 5'd5; write_data = 32'h0BAD0BAD; write_en = 1'b0;
    #1;
    check("no_bypass_when_idle", read_data_1, 32'h12345678);
    write_data = 32'h0;

    // Write to r0 is discarded: no bypass, no storage, no count.
    write_en = 1'b1; write_addr = 5'd0; write_data = 32'hDEADBEEF;
    read_addr_1 = 5'd0; read_addr_2 = 5'd0; debug_addr = 5'd0;
    #1;
    check("r0_same_cycle_rd1", read_data_1, 32'h0);
    tick();
    write_en = 1'b0; write_data = 32'h0;
    #1;
    check("r0_rd1", read_data_1, 32'h0);
    check("r0_rd2", read_data_2, 32'h0);
    check("r0_dbg", debug_data, 32'h0);
    check("r0_wc", write_count, 32'd1);

    // Bypass: r7 holds 0x11, new write visible on both ports that cycle.
    do_write(5'd7, 32'h00000011);
    write_en = 1'b1; write_addr = 5'd7; write_data = 32'hCAFEBABE;
    read_addr_1 = 5'd7; read_addr_2 = 5'd7; debug_addr = 5'd7;
    #1;
    check("byp_rd1", read_data_1, 32'hCAFEBABE);
    check("byp_rd2", read_data_2, 32'hCAFEBABE);
    check("byp_dbg_old", debug_data, 32'h00000011);
    tick();
    write_en = 1'b0; write_data = 32'h0; write_addr = 5'd0;
    #1;
    check("byp_dbg_new", debug_data, 32'hCAFEBABE);
    check("byp_rd1_stored", read_data_1, 32'hCAFEBABE);
    check("byp_wc", write_count, 32'd3);

    // Disabled port reads zero while the other port sees the stored value.
    do_write(5'd3, 32'h00000055);
    read_en_1 = 1'b0; read_addr_1 = 5'd3;
    read_en_2 = 1'b1; read_addr_2 = 5'd3;
    #1;
    check("en_off_rd1", read_data_1, 32'h0);
    check("en_on_rd2", read_data_2, 32'h00000055);
    check("en_wc", write_count, 32'd4);
    read_en_1 = 1'b1;

    // Mid-sequence asynchronous reset.
    do_write(5'd9, 32'h00000001);
    debug_addr = 5'd9; read_addr_1 = 5'd9;
    #1;
    check("r9_before_rst", debug_data, 32'h00000001);
    check("wc_before_rst", write_count, 32'd5);
    #2 rst = 1'b0;
    #1;
    check("r9_async_clr", debug_data, 32'h0);
    check("wc_async_clr", write_count, 32'h0);
    check("rd1_async_clr", read_data_1, 32'h0);
    write_en = 1'b1; write_addr = 5'd9; write_data = 32'h0000BEEF;
    tick();
    write_en = 1'b0; write_data = 32'h0; write_addr = 5'd0;
    #2 rst = 1'b1;
    #1;
    check("r9_write_in_rst", debug_data, 32'h0);
    for (int i = 0; i < 32; i++) begin
      debug_addr = 5'(i);
      #1;
      check($sformatf("post_rst_dbg_r%0d", i), debug_data, 32'h0);
    end
    check("post_rst_wc", write_count, 32'h0);

    // First write after release is honoured.
    do_write(5'd9, 32'h00000077);
    debug_addr = 5'd9;
    #1;
    check("r9_after_release", debug_data, 32'h00000077);
    check("wc_after_release", write_count, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
